// File: rtl/dual_port_mem_ws.sv
// dual_port_mem_ws
//   Dual-port memory with a per-port wait-state FSM (IDLE -> WAIT -> ACK).
//   Port A is read-only (instruction fetch). Port B reads or writes data.
//   A request is taken while the port is IDLE or ACK. The port then waits
//   WAIT_x cycles and completes the access on the edge that raises ack_x.
//   With WAIT_x=0 the access completes on the accepting edge itself, so a
//   held request gives one access per cycle.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   req_a, addr_a     port A read request / address
//   ack_a, instr_out  one-cycle completion pulse / read data (held)
//   busy_a            port A in WAIT
//   req_b, we_b       port B request / write enable
//   addr_b            port B address
//   write_data_b      port B write data
//   ack_b             one-cycle completion pulse (read or write)
//   data_out_b        port B read data (held; writes leave it unchanged)
//   busy_b            port B in WAIT
module dual_port_mem_ws #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int WAIT_A = 0,
  parameter int WAIT_B = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  output logic              ack_a,
  output logic [DATA_W-1:0] instr_out,
  output logic              busy_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] write_data_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] data_out_b,
  output logic              busy_b
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] WA = 3'(WAIT_A);
  localparam logic [2:0] WB = 3'(WAIT_B);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- port A ----------------
  state_t            st_a;
  logic [2:0]        cnt_a;
  logic [ADDR_W-1:0] addr_a_q;
  logic              acc_a, fire_a;
  logic [ADDR_W-1:0] rd_addr_a;

  assign acc_a  = req_a && (st_a == S_IDLE || st_a == S_ACK);
  // Zero wait states: the access happens on the accepting edge, using the
  // live address. Otherwise it happens on the last WAIT edge.
  assign fire_a = (acc_a && WA == 3'd0) || (st_a == S_WAIT && cnt_a == 3'd1);
  assign rd_addr_a = acc_a ? addr_a : addr_a_q;
  assign busy_a = (st_a == S_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_a      <= S_IDLE;
      cnt_a     <= 3'd0;
      addr_a_q  <= '0;
      ack_a     <= 1'b0;
      instr_out <= '0;
    end else begin
      ack_a <= fire_a;
      if (fire_a) instr_out <= mem[rd_addr_a];
      if (acc_a) begin
        addr_a_q <= addr_a;
        cnt_a    <= WA;
        st_a     <= (WA == 3'd0) ? S_ACK : S_WAIT;
      end else begin
        case (st_a)
          S_WAIT: begin
            cnt_a <= cnt_a - 3'd1;
            if (cnt_a == 3'd1) st_a <= S_ACK;
          end
          S_ACK:   st_a <= S_IDLE;
          default: st_a <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- port B ----------------
  state_t            st_b;
  logic [2:0]        cnt_b;
  logic [ADDR_W-1:0] addr_b_q;
  logic [DATA_W-1:0] wdata_b_q;
  logic              we_b_q;
  logic              acc_b, fire_b, we_sel, wr_b;
  logic [ADDR_W-1:0] addr_sel_b;
  logic [DATA_W-1:0] wdata_sel_b;

  assign acc_b       = req_b && (st_b == S_IDLE || st_b == S_ACK);
  assign fire_b      = (acc_b && WB == 3'd0) || (st_b == S_WAIT && cnt_b == 3'd1);
  assign we_sel      = acc_b ? we_b : we_b_q;
  assign addr_sel_b  = acc_b ? addr_b : addr_b_q;
  assign wdata_sel_b = acc_b ? write_data_b : wdata_b_q;
  // rst gate: a zero-wait request seen while reset is held must not write.
  assign wr_b        = rst && fire_b && we_sel;
  assign busy_b      = (st_b == S_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_b       <= S_IDLE;
      cnt_b      <= 3'd0;
      addr_b_q   <= '0;
      wdata_b_q  <= '0;
      we_b_q     <= 1'b0;
      ack_b      <= 1'b0;
      data_out_b <= '0;
    end else begin
      ack_b <= fire_b;
      if (fire_b && !we_sel) data_out_b <= mem[addr_sel_b];
      if (acc_b) begin
        addr_b_q  <= addr_b;
        wdata_b_q <= write_data_b;
        we_b_q    <= we_b;
        cnt_b     <= WB;
        st_b      <= (WB == 3'd0) ? S_ACK : S_WAIT;
      end else begin
        case (st_b)
          S_WAIT: begin
            cnt_b <= cnt_b - 3'd1;
            if (cnt_b == 3'd1) st_b <= S_ACK;
          end
          S_ACK:   st_b <= S_IDLE;
          default: st_b <= S_IDLE;
        endcase
      end
    end
  end

  // Storage has no reset. Reads above sample the pre-edge contents, so a
  // same-edge A read / B write to one address returns the old word.
  always_ff @(posedge clk) begin
    if (wr_b) mem[addr_sel_b] <= wdata_sel_b;
  end

endmodule
